// File: rtl/nios_debug_jtag_pkg.sv
// ============================================================================
// Module      : nios_debug_jtag_pkg
// Description : Shared state encodings and IR opcodes for the JTAG initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios_debug_jtag_pkg;

    localparam int DR_WIDTH_DEFAULT = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_UIR      = 3'd1;
    localparam state_t ST_CDR      = 3'd2;
    localparam state_t ST_SDR      = 3'd3;
    localparam state_t ST_UDR      = 3'd4;
    localparam state_t ST_RTI      = 3'd5;
    localparam state_t ST_WAIT_RSP = 3'd6;

endpackage

`default_nettype wire

// File: rtl/nios_debug_tck_gen.sv
// ============================================================================
// Module      : nios_debug_tck_gen
// Description : Divides clk into tck; flags the clk cycle before each tck edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int              DIV_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tck_q, tck_d;
    logic             half_done;

    always_comb begin
        half_done = run && (div_q == DIV_LAST);
        div_d     = div_q;
        tck_d     = tck_q;
        if (!run) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (half_done) begin
            div_d = '0;
            tck_d = ~tck_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck       = tck_q;
    assign rise_tick = half_done && !tck_q;
    assign fall_tick = half_done &&  tck_q;

endmodule

`default_nettype wire

// File: rtl/nios_debug_jtag_initiator.sv
// ============================================================================
// Module      : nios_debug_jtag_initiator
// Description : Runs one IR-update/capture/shift/update/idle sequence per command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_debug_jtag_initiator
    import nios_debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH   = DR_WIDTH_DEFAULT,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    // One counter serves both the SDR bit count and the RTI period count.
    localparam int               CNT_MAX  = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [1:0]          rsp_ir_q, rsp_ir_d;
    logic [1:0]          ir_in_q, ir_in_d;
    logic                run, rise_tick, fall_tick;

    assign run = (state_q != ST_IDLE) && (state_q != ST_WAIT_RSP);

    nios_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .tck       (vji_tck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rsp_dr_d = rsp_dr_q;
        rsp_ir_d = rsp_ir_q;
        ir_in_d  = ir_in_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                state_d = ST_UIR;
                ir_in_d = cmd_ir;
                shift_d = cmd_dr;
                cnt_d   = '0;
            end
            ST_UIR: begin
                if (rise_tick) rsp_ir_d = vji_ir_out;
                if (fall_tick) state_d = ST_CDR;
            end
            ST_CDR: if (fall_tick) begin
                state_d = ST_SDR;
                cnt_d   = '0;
            end
            ST_SDR: begin
                if (rise_tick) shift_d = {vji_tdo, shift_q[DR_WIDTH-1:1]};
                if (fall_tick) begin
                    if (cnt_q == SDR_LAST) begin
                        state_d  = ST_UDR;
                        rsp_dr_d = shift_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_UDR: if (fall_tick) begin
                state_d = ST_RTI;
                cnt_d   = '0;
            end
            ST_RTI: if (fall_tick) begin
                if (cnt_q == RTI_LAST) begin
                    state_d = ST_WAIT_RSP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RSP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            rsp_dr_q <= '0;
            rsp_ir_q <= 2'd0;
            ir_in_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rsp_dr_q <= rsp_dr_d;
            rsp_ir_q <= rsp_ir_d;
            ir_in_q  <= ir_in_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_WAIT_RSP);
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_tdi    = (state_q == ST_SDR) && shift_q[0];
    assign vji_uir    = (state_q == ST_UIR);
    assign vji_cdr    = (state_q == ST_CDR);
    assign vji_sdr    = (state_q == ST_SDR);
    assign vji_udr    = (state_q == ST_UDR);
    assign vji_rti    = (state_q == ST_IDLE) || (state_q == ST_RTI);

endmodule

`default_nettype wire

// File: tb/tb_nios_debug_jtag_initiator.sv
// ============================================================================
// Module      : tb_nios_debug_jtag_initiator
// Description : Directed bench with a loopback debug-slave model per instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_debug_jtag_initiator;

    localparam logic [37:0] SLAVE_LOAD = 38'h2A_DEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_valid1 = 1'b0;
    logic        rsp_ready = 1'b0, rsp_ready1 = 1'b0;
    logic [1:0]  cmd_ir = 2'd0;
    logic [37:0] cmd_dr = '0;
    logic [1:0]  vji_ir_out = 2'd0;

    logic        cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
    logic [37:0] rsp_dr;
    logic [1:0]  rsp_ir_out, vji_ir_in;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic        cmd_ready1, rsp_valid1, vji_tck1, vji_tdi1, vji_tdo1;
    logic [37:0] rsp_dr1;
    logic [1:0]  rsp_ir_out1, vji_ir_in1;
    logic        vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios_debug_jtag_initiator dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    nios_debug_jtag_initiator #(.DR_WIDTH(38), .TCK_DIV(1), .RTI_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1), .vji_tck(vji_tck1), .vji_tdi(vji_tdi1),
        .vji_tdo(vji_tdo1), .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1), .vji_udr(vji_udr1),
        .vji_rti(vji_rti1)
    );

    // Slave models act on strobe/tdi values seen before the tck rising edge.
    logic [37:0] sreg0 = '0, sreg1 = '0;
    logic [4:0]  strb_s = '0;
    logic        tck_s = 1'b0, tdi_s = 1'b0;
    logic        cdr1_s = 1'b0, sdr1_s = 1'b0, tdi1_s = 1'b0;
    int          uir_n = 0, cdr_n = 0, sdr_n = 0, udr_n = 0, rti_n = 0, stab_n = 0;

    assign vji_tdo  = sreg0[0];
    assign vji_tdo1 = sreg1[0];

    always @(negedge clk) begin
        if (!tck_s && vji_tck && ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== strb_s))
            stab_n <= stab_n + 1;
        tck_s  <= vji_tck;
        tdi_s  <= vji_tdi;
        strb_s <= {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        tdi1_s <= vji_tdi1;
        cdr1_s <= vji_cdr1;
        sdr1_s <= vji_sdr1;
    end

    always @(posedge vji_tck) begin
        if (strb_s[3])      sreg0 <= SLAVE_LOAD;
        else if (strb_s[2]) sreg0 <= {tdi_s, sreg0[37:1]};
        uir_n <= uir_n + int'(strb_s[4]);
        cdr_n <= cdr_n + int'(strb_s[3]);
        sdr_n <= sdr_n + int'(strb_s[2]);
        udr_n <= udr_n + int'(strb_s[1]);
        rti_n <= rti_n + int'(strb_s[0]);
    end

    always @(posedge vji_tck1) begin
        if (cdr1_s)      sreg1 <= SLAVE_LOAD;
        else if (sdr1_s) sreg1 <= {tdi1_s, sreg1[37:1]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and waits (bounded) for its response; lat counts the accept cycle.
    task automatic do_cmd(input int which, input logic [1:0] ir, input logic [37:0] dr,
                          output int lat);
        @(negedge clk);
        cmd_ir = ir;
        cmd_dr = dr;
        if (which == 0) cmd_valid = 1'b1; else cmd_valid1 = 1'b1;
        check("ready_before_accept", (which == 0) ? cmd_ready : cmd_ready1, 64'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_valid1 = 1'b0;
        lat = 1;
        check("busy_after_accept", (which == 0) ? cmd_ready : cmd_ready1, 64'd0);
        check("uir_first", (which == 0) ? vji_uir : vji_uir1, 64'd1);
        check("ir_in_latched", (which == 0) ? vji_ir_in : vji_ir_in1, 64'(ir));
        while (!((which == 0) ? rsp_valid : rsp_valid1) && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input int which);
        @(negedge clk);
        if (which == 0) rsp_ready = 1'b1; else rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready  = 1'b0;
        rsp_ready1 = 1'b0;
        check("valid_dropped", (which == 0) ? rsp_valid : rsp_valid1, 64'd0);
        check("ready_back", (which == 0) ? cmd_ready : cmd_ready1, 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tck"}, vji_tck, 64'd0);
        check({tag, "_tdi"}, vji_tdi, 64'd0);
        check({tag, "_ir_in"}, vji_ir_in, 64'd0);
        check({tag, "_strobes"}, {vji_uir, vji_cdr, vji_sdr, vji_udr}, 64'd0);
        check({tag, "_rti"}, vji_rti, 64'd1);
        check({tag, "_cmd_ready"}, cmd_ready, 64'd1);
        check({tag, "_rsp_valid"}, rsp_valid, 64'd0);
        check({tag, "_rsp_dr"}, rsp_dr, 64'd0);
        check({tag, "_rsp_ir"}, rsp_ir_out, 64'd0);
    endtask

    initial begin
        int lat, k;
        int u0, c0, s0, d0, r0, st0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check("reset_cmd_ready1", cmd_ready1, 64'd1);
        reset = 1'b0;

        // Loopback with default parameters
        vji_ir_out = 2'b01;
        u0 = uir_n; c0 = cdr_n; s0 = sdr_n; d0 = udr_n; r0 = rti_n; st0 = stab_n;
        do_cmd(0, 2'd0, 38'h15_12345678, lat);
        check("lat_default", 64'(lat), 64'd173);
        check("loop_rsp_dr", rsp_dr, 64'h2A_DEADBEEF);
        check("loop_slave_rx", sreg0, 64'h15_12345678);
        check("loop_rsp_ir", rsp_ir_out, 64'h1);
        check("cnt_uir", 64'(uir_n - u0), 64'd1);
        check("cnt_cdr", 64'(cdr_n - c0), 64'd1);
        check("cnt_sdr", 64'(sdr_n - s0), 64'd38);
        check("cnt_udr", 64'(udr_n - d0), 64'd1);
        check("cnt_rti", 64'(rti_n - r0), 64'd2);
        check("strobe_stability", 64'(stab_n - st0), 64'd0);

        // Backpressure: response held, a competing command must be ignored
        cmd_valid = 1'b1;
        cmd_ir    = 2'd2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 64'd1);
            check("bp_tck", vji_tck, 64'd0);
            check("bp_cmd_ready", cmd_ready, 64'd0);
        end
        cmd_valid = 1'b0;
        check("bp_ir_in_held", vji_ir_in, 64'd0);
        ack(0);
        check("rsp_dr_held", rsp_dr, 64'h2A_DEADBEEF);
        check("ir_in_held_idle", vji_ir_in, 64'd0);

        // IR readback
        vji_ir_out = 2'b10;
        do_cmd(0, 2'd3, 38'h3F_00FF00FF, lat);
        check("lat_ir", 64'(lat), 64'd173);
        check("ir_rsp_ir", rsp_ir_out, 64'h2);
        check("ir_rsp_dr", rsp_dr, 64'h2A_DEADBEEF);
        check("ir_slave_rx", sreg0, 64'h3F_00FF00FF);
        ack(0);
        check("ir_in_kept", vji_ir_in, 64'd3);

        // Reset after ten SDR bits
        @(negedge clk);
        cmd_ir    = 2'd2;
        cmd_dr    = 38'h01_11111111;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        s0 = sdr_n;
        k  = 0;
        while ((sdr_n - s0) < 10 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("sdr10_reached", 64'(sdr_n - s0), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_no_rsp", rsp_valid, 64'd0);
        vji_ir_out = 2'b11;
        do_cmd(0, 2'd1, 38'h00_CAFEF00D, lat);
        check("lat_after_reset", 64'(lat), 64'd173);
        check("after_reset_rsp_dr", rsp_dr, 64'h2A_DEADBEEF);
        check("after_reset_slave_rx", sreg0, 64'h00_CAFEF00D);
        check("after_reset_rsp_ir", rsp_ir_out, 64'h3);
        ack(0);

        // Fast instance: TCK_DIV=1, RTI_CYCLES=1
        vji_ir_out = 2'b01;
        do_cmd(1, 2'd2, 38'h2B_A5A55A5A, lat);
        check("lat_fast", 64'(lat), 64'd85);
        check("fast_rsp_dr", rsp_dr1, 64'h2A_DEADBEEF);
        check("fast_slave_rx", sreg1, 64'h2B_A5A55A5A);
        check("fast_rsp_ir", rsp_ir_out1, 64'h1);
        ack(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
